// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU clients and the shared-ALU arbiter.
// The master modport is the client side; the slave modport is the arbiter side.
interface alu_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_s;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_s;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_zero;

  modport master (
    output req_valid, req0_a, req0_b, req0_s, req1_a, req1_b, req1_s, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_zero
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_s, req1_a, req1_b, req1_s, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit ALU between two requesters.
// Each operation walks IDLE -> EXEC -> RESP; the result is held until its owner consumes it.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (s)
      2'b00:   y = a & b;
      2'b01:   y = a | b;
      2'b10:   y = a + b;
      default: y = a - b;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus,
  output logic          busy
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             last_reg;
  logic             owner_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       s_reg;
  logic [WIDTH-1:0] y_reg;
  logic             zero_reg;

  logic [WIDTH-1:0] req_a [2];
  logic [WIDTH-1:0] req_b [2];
  logic [1:0]       req_s [2];
  logic             grant_any;
  logic             grant_idx;
  logic             grant;
  logic [WIDTH-1:0] alu_y;

  assign req_a[0] = bus.req0_a;
  assign req_b[0] = bus.req0_b;
  assign req_s[0] = bus.req0_s;
  assign req_a[1] = bus.req1_a;
  assign req_b[1] = bus.req1_b;
  assign req_s[1] = bus.req1_s;

  // On a tie the requester that did not win last time goes next.
  assign grant_any = |bus.req_valid;
  assign grant_idx = (&bus.req_valid) ? ~last_reg : bus.req_valid[1];
  assign grant     = (state_reg == IDLE) && grant_any;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign bus.req_ready[gi] = grant && !reset && (grant_idx == 1'(gi));
      assign bus.rsp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign bus.rsp_y    = y_reg;
  assign bus.rsp_zero = zero_reg;
  assign busy         = (state_reg != IDLE);

  // The ALU only ever sees the captured operands, so clients may change inputs after acceptance.
  alu #(.WIDTH(WIDTH)) u_alu (
    .a (a_reg),
    .b (b_reg),
    .s (s_reg),
    .y (alu_y)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      owner_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      y_reg     <= '0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        a_reg     <= req_a[grant_idx];
        b_reg     <= req_b[grant_idx];
        s_reg     <= req_s[grant_idx];
        owner_reg <= grant_idx;
        last_reg  <= grant_idx;
      end
      if (state_reg == EXEC) begin
        y_reg    <= alu_y;
        zero_reg <= (alu_y == '0);
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected results are queued at grant time and
// popped when the matching response appears.
module tb_alu_arbiter;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       v;
    logic [WIDTH-1:0] y;
    logic             z;
  } rsp_t;

  rsp_t sb[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [1:0] s);
    logic [WIDTH-1:0] r;
    case (s)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = WIDTH'(a + b);
      default: r = WIDTH'(a - b);
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the grant and, if one is expected, queues the result the winner should receive.
  task automatic expect_grant(input string tag, input logic [1:0] exp);
    rsp_t e;
    #1;
    chk(tag, {30'd0, bus.req_ready}, {30'd0, exp});
    if (exp != 2'b00) begin
      e.v = exp;
      e.y = exp[0] ? ref_alu(bus.req0_a, bus.req0_b, bus.req0_s)
                   : ref_alu(bus.req1_a, bus.req1_b, bus.req1_s);
      e.z = (e.y == '0);
      sb.push_back(e);
    end
  endtask

  task automatic wait_rsp(input string tag);
    rsp_t e;
    int   n = 0;
    while (bus.rsp_valid == 2'b00 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, {31'd0, (bus.rsp_valid != 2'b00)}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {30'd0, bus.rsp_valid}, {30'd0, e.v});
      chk({tag, "_y"}, {28'd0, bus.rsp_y}, {28'd0, e.y});
      chk({tag, "_zero"}, {31'd0, bus.rsp_zero}, {31'd0, e.z});
    end
  endtask

  // One full operation with rsp_ready assumed high for the owner.
  task automatic do_op(input string tag, input logic [1:0] exp);
    expect_grant({tag, "_grant"}, exp);
    tick();
    chk({tag, "_exec_rdy"}, {30'd0, bus.req_ready}, 32'd0);
    chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_exec_vld"}, {30'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk({tag, "_latency"}, {30'd0, bus.rsp_valid}, {30'd0, exp});
    wait_rsp(tag);
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 2'b11;
    bus.req0_a    = '0;
    bus.req0_b    = '0;
    bus.req0_s    = '0;
    bus.req1_a    = '0;
    bus.req1_b    = '0;
    bus.req1_s    = '0;
    bus.rsp_ready = 2'b00;
    tick();
    tick();
    chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_y", {28'd0, bus.rsp_y}, 32'd0);
    chk("rst_rsp_zero", {31'd0, bus.rsp_zero}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    bus.req_valid = 2'b00;
    reset         = 1'b0;
    tick();

    // Single SUB with underflow, exact latency checked step by step.
    bus.req0_a = 4'h0; bus.req0_b = 4'h1; bus.req0_s = 2'b11;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    expect_grant("sub_grant", 2'b01);
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("sub_exec_busy", {31'd0, busy}, 32'd1);
    chk("sub_exec_vld", {30'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("sub_latency", {30'd0, bus.rsp_valid}, 32'h1);
    wait_rsp("sub");
    tick();
    chk("sub_idle_busy", {31'd0, busy}, 32'd0);

    // Contention after a fresh reset: grants alternate starting with requester 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req0_a = 4'hF; bus.req0_b = 4'h2; bus.req0_s = 2'b10;
    bus.req1_a = 4'h3; bus.req1_b = 4'hC; bus.req1_s = 2'b01;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    do_op("rr0", 2'b01);
    do_op("rr1", 2'b10);
    do_op("rr2", 2'b01);
    do_op("rr3", 2'b10);

    // AND producing zero on requester 1.
    bus.req1_a = 4'h0; bus.req1_b = 4'h7; bus.req1_s = 2'b00;
    bus.req_valid = 2'b10;
    do_op("and0", 2'b10);

    // Backpressure: result held, req1 waits, then wins right after consumption.
    bus.req0_a = 4'hE; bus.req0_b = 4'h2; bus.req0_s = 2'b11;
    bus.req1_a = 4'h1; bus.req1_b = 4'h1; bus.req1_s = 2'b10;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    expect_grant("bp_grant", 2'b01);
    tick();
    bus.req_valid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_vld", {30'd0, bus.rsp_valid}, 32'h1);
      chk("bp_hold_y", {28'd0, bus.rsp_y}, 32'hC);
      chk("bp_hold_rdy", {30'd0, bus.req_ready}, 32'd0);
      chk("bp_hold_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    wait_rsp("bp");
    bus.rsp_ready = 2'b11;
    tick();
    do_op("bp_next", 2'b10);

    // Operands change the cycle after acceptance.
    bus.req0_a = 4'h2; bus.req0_b = 4'h2; bus.req0_s = 2'b10;
    bus.req_valid = 2'b01;
    expect_grant("opchg_grant", 2'b01);
    tick();
    bus.req0_a = 4'hF; bus.req0_b = 4'hF;
    bus.req_valid = 2'b00;
    tick();
    wait_rsp("opchg");
    tick();

    // Reset during EXEC discards the op; the next tie goes to requester 0.
    bus.req0_a = 4'h5; bus.req0_b = 4'h3; bus.req0_s = 2'b10;
    bus.req_valid = 2'b01;
    #1;
    chk("rmid_grant", {30'd0, bus.req_ready}, 32'h1);
    tick();
    bus.req_valid = 2'b11;
    reset = 1'b1;
    #1;
    chk("rmid_vld", {30'd0, bus.rsp_valid}, 32'd0);
    chk("rmid_y", {28'd0, bus.rsp_y}, 32'd0);
    chk("rmid_zero", {31'd0, bus.rsp_zero}, 32'd0);
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_rdy", {30'd0, bus.req_ready}, 32'd0);
    tick();
    tick();
    chk("rmid_vld_hold", {30'd0, bus.rsp_valid}, 32'd0);
    reset = 1'b0;
    bus.req0_a = 4'h9; bus.req0_b = 4'h6; bus.req0_s = 2'b01;
    #1;
    chk("rmid_no_pulse", {30'd0, bus.rsp_valid}, 32'd0);
    do_op("rmid_tie", 2'b01);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
